// File: rtl/utf8_stream_decoder.sv
// UTF-8 stream decoder.
// Raw receiver bytes are buffered in a byte FIFO and decoded into 21-bit code
// points. Malformed input is replaced by U+FFFD and flagged with decode_error.
// Each code point is delivered as a one-cycle unicode_available pulse. Pulses
// are gated by ready_n and by a holdoff counter.
module utf8_stream_decoder #(
  parameter int FIFO_DEPTH = 16,
  parameter int HOLDOFF    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        ready_n,
  output logic [20:0] unicode,
  output logic        unicode_available,
  output logic        fifo_full,
  output logic        overflow,
  output logic        decode_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   LAST_IDX   = (AW + 1)'(FIFO_DEPTH - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLDOFF);
  localparam logic [20:0]   REPLACEMENT = 21'h00FFFD;

  typedef enum logic [1:0] {
    LEAD,
    CONT,
    OUT
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic [AW:0] count_next;
  logic        push;
  logic        pop;
  logic        empty;
  logic [7:0]  head;

  // Decoder state
  state_t        state;
  logic [20:0]   acc;
  logic [1:0]    remaining;
  logic          first_cont;
  logic [7:0]    lead_byte;
  logic          is_err;
  logic [HW-1:0] holdoff;

  // Continuation range check
  logic [7:0] cont_lo;
  logic [7:0] cont_hi;
  logic       in_range;

  assign empty = (count == '0);
  assign head  = mem[rd_ptr[AW-1:0]];
  // fifo_full is the registered value, so a same-cycle pop cannot rescue a write
  assign push  = rx_valid && !fifo_full;
  assign pop   = !empty && ((state == LEAD) || ((state == CONT) && in_range));

  function automatic logic [AW:0] wrap_inc(input logic [AW:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Allowed window for the continuation byte at the FIFO head
  always_comb begin
    cont_lo = 8'h80;
    cont_hi = 8'hBF;
    if (first_cont) begin
      case (lead_byte)
        8'hE0:   cont_lo = 8'hA0;
        8'hED:   cont_hi = 8'h9F;
        8'hF0:   cont_lo = 8'h90;
        8'hF4:   cont_hi = 8'h8F;
        default: ;
      endcase
    end
    in_range = (head >= cont_lo) && (head <= cont_hi);
  end

  // Next FIFO occupancy
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (!push && pop) begin
      count_next = count - 1'b1;
    end
  end

  // FIFO byte storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= rx_data;
    end
  end

  // FIFO pointers, occupancy, full and sticky overflow flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wrap_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= wrap_inc(rd_ptr);
      end
      count     <= count_next;
      fifo_full <= (count_next == FULL_COUNT);
      if (rx_valid && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Decode FSM, holdoff counter and registered output pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= LEAD;
      acc               <= '0;
      remaining         <= '0;
      first_cont        <= 1'b0;
      lead_byte         <= '0;
      is_err            <= 1'b0;
      holdoff           <= '0;
      unicode           <= '0;
      unicode_available <= 1'b0;
      decode_error      <= 1'b0;
    end else begin
      unicode_available <= 1'b0;
      decode_error      <= 1'b0;
      if (holdoff != '0) begin
        holdoff <= holdoff - 1'b1;
      end
      case (state)
        LEAD: begin
          if (!empty) begin
            lead_byte  <= head;
            first_cont <= 1'b1;
            is_err     <= 1'b0;
            if (head < 8'h80) begin
              acc   <= {13'b0, head};
              state <= OUT;
            end else if ((head >= 8'hC2) && (head <= 8'hDF)) begin
              acc       <= {16'b0, head[4:0]};
              remaining <= 2'd1;
              state     <= CONT;
            end else if ((head >= 8'hE0) && (head <= 8'hEF)) begin
              acc       <= {17'b0, head[3:0]};
              remaining <= 2'd2;
              state     <= CONT;
            end else if ((head >= 8'hF0) && (head <= 8'hF4)) begin
              acc       <= {18'b0, head[2:0]};
              remaining <= 2'd3;
              state     <= CONT;
            end else begin
              acc    <= REPLACEMENT;
              is_err <= 1'b1;
              state  <= OUT;
            end
          end
        end
        CONT: begin
          // A rejected byte stays in the FIFO and is re-read as a lead byte
          if (!empty) begin
            if (in_range) begin
              acc        <= {acc[14:0], head[5:0]};
              first_cont <= 1'b0;
              remaining  <= remaining - 2'd1;
              if (remaining == 2'd1) begin
                state <= OUT;
              end
            end else begin
              acc    <= REPLACEMENT;
              is_err <= 1'b1;
              state  <= OUT;
            end
          end
        end
        OUT: begin
          // The holdoff load here overrides the decrement above
          if ((holdoff == '0) && !ready_n) begin
            unicode           <= acc;
            unicode_available <= 1'b1;
            decode_error      <= is_err;
            holdoff           <= HOLD_LOAD;
            state             <= LEAD;
          end
        end
        default: state <= LEAD;
      endcase
    end
  end

endmodule

// File: doc/utf8_stream_decoder.md
Name: utf8_stream_decoder

Overview:
- Sits between the serial receiver and the terminal stream interpreter.
- Buffers raw received bytes in a small FIFO and decodes UTF-8 into 21-bit code points. Malformed input becomes U+FFFD.
- Delivers each code point as a single-cycle unicode_available pulse, paced by the interpreter's ready_n.

Parameters:
FIFO_DEPTH, 16, byte FIFO depth; power of 2, minimum 4.
HOLDOFF, 2, minimum idle cycles after each output pulse before ready_n is sampled again; minimum 1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
rx_data  in  8  received byte
rx_valid  in  1  single-cycle strobe; rx_data valid
ready_n  in  1  0 = interpreter can take a code point
unicode  out  21  decoded code point; held stable between pulses
unicode_available  out  1  single-cycle strobe; unicode valid
fifo_full  out  1  FIFO holds FIFO_DEPTH bytes
overflow  out  1  sticky; a byte was dropped
decode_error  out  1  single-cycle strobe, coincident with a U+FFFD output pulse

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset clears all outputs to 0: unicode=0, unicode_available=0, fifo_full=0, overflow=0, decode_error=0.
- Reset also empties the FIFO, discards any partial sequence, clears the holdoff counter and returns the FSM to LEAD. Reset mid-sequence emits nothing.
- FIFO write: on rx_valid with fifo_full=0 the byte is stored.
- FIFO overflow: on rx_valid with fifo_full=1 the byte is dropped and overflow sets. fifo_full is the value before the edge, so a same-cycle pop does not rescue the write.
- FIFO read: at most one pop per cycle, in LEAD or CONT only, when the FIFO is non-empty.
- Pointer/count widths are log2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
- FSM states: LEAD, CONT, OUT.
- LEAD pops a byte and classifies it:
  - 00-7F: code point = byte -> OUT.
  - C2-DF: acc = byte[4:0], remaining=1 -> CONT.
  - E0-EF: acc = byte[3:0], remaining=2 -> CONT.
  - F0-F4: acc = byte[2:0], remaining=3 -> CONT.
  - 80-BF, C0, C1, F5-FF: FFFD with error -> OUT.
- Latch the lead byte for the second-byte range check.
- CONT peeks the FIFO head.
- Allowed range for the first continuation byte (second byte of the sequence):
  - after E0: A0-BF
  - after ED: 80-9F
  - after F0: 90-BF
  - after F4: 80-8F
  - otherwise: 80-BF
- Allowed range for later continuation bytes: 80-BF.
- CONT, byte in range: pop it; acc = {acc, byte[5:0]}; remaining decrements; at 0 -> OUT.
- CONT, byte out of range: do NOT pop; FFFD with error -> OUT. The offending byte is re-decoded as a lead byte afterwards.
- CONT with the FIFO empty waits indefinitely; there is no timeout.
- acc is 21 bits; the range checks guarantee results lie in 0x80..0x10FFFF excluding D800-DFFF, with no overlongs.
- OUT waits until the holdoff counter is 0 and ready_n==0 (sampled this cycle). Then, for one cycle:
  - unicode is loaded;
  - unicode_available=1;
  - decode_error is set if FFFD came from an error.
- After a pulse, the holdoff counter loads HOLDOFF and decrements each cycle; the FSM returns to LEAD.
- Decoding of the next code point proceeds during holdoff; only the pulse is gated.
- Latency: an ASCII byte strobed at edge n with an empty FIFO, FSM in LEAD, holdoff 0 and ready_n=0 gives unicode_available high in the cycle after edge n+2.
- Sustained throughput is 1 code point per (HOLDOFF+1) cycles at best.
- If ready_n rises while in OUT, no pulse is issued; the code point is held until ready_n returns to 0.
- unicode_available is never high in two consecutive cycles.

Test Plan:
- Reset, ready_n=0, rx 0x41 -> one pulse with unicode=0x041, decode_error=0, exactly 3 cycles after the strobe; fifo_full and overflow stay 0.
- rx E2 82 AC, then F0 9F 98 80 -> pulses with unicode=0x020AC, then 0x1F600; the gap between pulses is ≥ HOLDOFF+1 cycles.
- rx C0 AF -> two pulses, both FFFD with decode_error=1.
- rx ED A0 80 -> three pulses, FFFD each: the first from the ED/A0 surrogate check, then A0 and 80 rejected as leads.
- rx E2 41 -> FFFD with error, then 0x041 without error.
- ready_n held 1 while sending 18 ASCII bytes:
  - no pulses during the stall;
  - fifo_full asserts once the FIFO is full;
  - overflow=1 after the dropped bytes;
  - releasing ready_n yields, in order, the bytes that were not dropped.
- Assert reset for 1 cycle after rx F0 9F, then rx 0x42 -> only 0x042 is emitted; overflow=0.
